// File: rtl/load_store_unit_pkg.sv
// ----------------------------------------------------------------------------
// load_store_unit_pkg
//   Shared types for the load/store unit: memory access size encoding and
//   the LSU state machine encoding.
//   No ports (package).
// ----------------------------------------------------------------------------
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
//   Purely combinational lane logic for RV32I loads and stores.
//   Ports:
//     size_i       access size (mem_size_t encoding, 2'b11 behaves as word)
//     uns_i        zero-extend loads instead of sign-extend
//     offset_i     byte address bits [1:0]
//     wdata_i      low-aligned store data
//     rdata_i      full memory word returned by a load
//     be_o         store byte enables
//     wdata_o      lane-replicated store data
//     rdata_o      extracted and extended load data
//     misaligned_o half on odd address, or word not on a 4-byte boundary
// ----------------------------------------------------------------------------
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [1:0]  lane;
    logic [31:0] shifted;

    always_comb begin
        lane         = 2'b00;
        be_o         = BE_ALL;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        case (size_i)
            MEM_BYTE: begin
                lane    = offset_i;
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_HALF: begin
                // A misaligned half still uses the half-word lane it falls in.
                lane         = {offset_i[1], 1'b0};
                be_o         = 4'b0011 << lane;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = offset_i[0];
            end
            default: begin
                misaligned_o = (offset_i != 2'b00);
            end
        endcase

        shifted = rdata_i >> {lane, 3'b000};

        case (size_i)
            MEM_BYTE: rdata_o = {{24{~uns_i & shifted[7]}}, shifted[7:0]};
            MEM_HALF: rdata_o = {{16{~uns_i & shifted[15]}}, shifted[15:0]};
            default:  rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//   Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW on a req/gnt/rvalid data memory
//   port and stalls the core until the access completes.
//   Optional feature macro: LSU_MISALIGN_TRAP_EN (adds lsu_misaligned_o and
//   completes misaligned accesses without touching memory).
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     lsu_req_i ..        core side request (held while lsu_stall_o=1)
//     lsu_rdata_o         extended load data, valid with lsu_done_o
//     lsu_stall_o         freeze PC/pipeline
//     lsu_done_o          one-cycle commit pulse
//     dmem_*_o            registered memory request
//     dmem_gnt_i          request accepted
//     dmem_rvalid_i/rdata response (load data or store ack)
//     lsu_misaligned_o    misaligned trap flag (only with the macro)
//     lsu_state_o         current FSM state (debug)
//
//   Handshake: dmem_req_o rises in the cycle after the core request is
//   accepted and stays high with every dmem_* field stable until a cycle in
//   which dmem_gnt_i=1; it drops on the next edge. Exactly one dmem_rvalid_i
//   is then expected, no earlier than the cycle after the grant.
// ----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [1:0]        lsu_size_i,
    input  logic              lsu_uns_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_stall_o,
    output logic              lsu_done_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              lsu_misaligned_o,
`endif
    output lsu_state_t        lsu_state_o
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [3:0]        dmem_be_q, dmem_be_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // In IDLE the lane logic looks at the live request (to build the memory
    // request); afterwards it looks at the latched fields (to extract loads).
    logic              in_idle;
    logic [1:0]        align_size;
    logic              align_uns;
    logic [1:0]        align_off;
    logic [3:0]        align_be;
    logic [DATA_W-1:0] align_wdata;
    logic [DATA_W-1:0] align_rdata;
    logic              align_mis;
    logic              trap;

    assign in_idle    = (state_q == IDLE);
    assign align_size = in_idle ? lsu_size_i      : size_q;
    assign align_uns  = in_idle ? lsu_uns_i       : uns_q;
    assign align_off  = in_idle ? lsu_addr_i[1:0] : off_q;

    lsu_align u_align (
        .size_i       (align_size),
        .uns_i        (align_uns),
        .offset_i     (align_off),
        .wdata_i      (lsu_wdata_i),
        .rdata_i      (dmem_rdata_i),
        .be_o         (align_be),
        .wdata_o      (align_wdata),
        .rdata_o      (align_rdata),
        .misaligned_o (align_mis)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign trap             = align_mis;
    assign lsu_misaligned_o = mis_q;
`else
    logic misaligned_unused;
    assign misaligned_unused = align_mis;
    assign trap              = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_be_d    = dmem_be_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        rdata_d      = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d        = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    we_d   = lsu_we_i;
                    size_d = lsu_size_i;
                    uns_d  = lsu_uns_i;
                    off_d  = lsu_addr_i[1:0];
                    if (trap) begin
                        // Misaligned trap: complete without a memory request.
                        state_d = DONE;
                        rdata_d = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        mis_d   = 1'b1;
`endif
                    end else begin
                        state_d      = REQ;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = lsu_we_i;
                        dmem_be_d    = lsu_we_i ? align_be : BE_ALL;
                        dmem_addr_d  = {lsu_addr_i[ADDR_W-1:2], 2'b00};
                        dmem_wdata_d = align_wdata;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    dmem_req_d = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    rdata_d = we_q ? '0 : align_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
                mis_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_be_q    <= 4'b0000;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            rdata_q      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_be_q    <= dmem_be_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            rdata_q      <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q        <= mis_d;
`endif
        end
    end

    // The core is released in DONE so the instruction commits that cycle.
    assign lsu_stall_o  = lsu_req_i & (state_q != DONE);
    assign lsu_done_o   = (state_q == DONE);
    assign lsu_rdata_o  = rdata_q;
    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_be_o    = dmem_be_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign lsu_state_o  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed and random load/store traffic against a byte-array reference
//   memory. A responder models the data memory with programmable grant and
//   response delays; a monitor checks every completed instruction.
// ----------------------------------------------------------------------------
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        lsu_req_i, lsu_we_i, lsu_uns_i;
    logic [1:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic        lsu_stall_o, lsu_done_o;
    logic        dmem_req_o, dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    lsu_state_t  dbg_state;
    logic        mis_act;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        lsu_misaligned_o;
    assign mis_act = lsu_misaligned_o;
`else
    assign mis_act = 1'b0;
`endif

    load_store_unit dut (
        .clk           (clk),
        .reset         (rst),
        .lsu_req_i     (lsu_req_i),
        .lsu_we_i      (lsu_we_i),
        .lsu_size_i    (lsu_size_i),
        .lsu_uns_i     (lsu_uns_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_rdata_o   (lsu_rdata_o),
        .lsu_stall_o   (lsu_stall_o),
        .lsu_done_o    (lsu_done_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
`ifdef LSU_MISALIGN_TRAP_EN
        .lsu_misaligned_o (lsu_misaligned_o),
`endif
        .lsu_state_o   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_total = 0;
    int n_pass  = 0;
    logic [32:0] exp_q[$];   // {misaligned, rdata} per completed instruction
    logic [68:0] req_q[$];   // {we, addr, be, store wdata} per memory request
    int gnt_delay    = 0;
    int rv_delay     = 0;
    int last_req_cnt = 0;

    logic [31:0] mem_w [256];   // memory seen by the DUT
    logic [7:0]  mdl   [1024];  // reference byte memory

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] val);
        mem_w[addr[9:2]] = val;
        for (int i = 0; i < 4; i++) mdl[int'(addr[9:2]) * 4 + i] = val[8*i +: 8];
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input string name);
        int n, eff, cycles;
        logic [31:0] val, exp_rd, exp_wd;
        logic [3:0]  be;
        logic        mis, mis_trap, stall_bad;
        n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
        eff = int'(addr[9:0]) / n * n;
        be  = 4'hf;
        if (we) begin
            be = 4'h0;
            for (int i = 0; i < n; i++) be[(eff % 4) + i] = 1'b1;
        end
        for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*(j % n) +: 8];
        mis_trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_trap = mis;
`endif
        exp_rd = 32'h0;
        if (mis_trap) begin
            exp_q.push_back({1'b1, 32'h0});
        end else begin
            req_q.push_back({we, addr & 32'hffff_fffc, be, we ? exp_wd : 32'h0});
            if (we) begin
                for (int i = 0; i < n; i++) mdl[eff + i] = wd[8*i +: 8];
            end else begin
                val = 32'h0;
                for (int i = 0; i < n; i++) val[8*i +: 8] = mdl[eff + i];
                if (n == 1)      exp_rd = uns ? {24'h0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
                else if (n == 2) exp_rd = uns ? {16'h0, val[15:0]} : {{16{val[15]}}, val[15:0]};
                else             exp_rd = val;
            end
            exp_q.push_back({1'b0, exp_rd});
        end

        lsu_req_i   = 1'b1;
        lsu_we_i    = we;
        lsu_size_i  = size;
        lsu_uns_i   = uns;
        lsu_addr_i  = addr;
        lsu_wdata_i = wd;
        cycles      = 0;
        stall_bad   = 1'b0;
        #1;
        if (!lsu_stall_o) stall_bad = 1'b1;
        do begin
            @(negedge clk);
            cycles++;
            if (!lsu_done_o && !lsu_stall_o) stall_bad = 1'b1;
        end while (!lsu_done_o && cycles < 200);
        check({name, " done"}, lsu_done_o, 1'b1);
        if (lsu_stall_o) stall_bad = 1'b1;
        check({name, " stall"}, stall_bad, 1'b0);
        if (exp_lat > 0) check({name, " latency"}, cycles, exp_lat);
        lsu_req_i = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- data memory responder ----------------
    task automatic serve();
        logic [31:0] a;
        logic [3:0]  b;
        logic        stable;
        int          cnt;
        a = dmem_addr_o;
        b = dmem_be_o;
        stable = 1'b1;
        cnt = 1;
        for (int i = 0; i < gnt_delay; i++) begin
            @(negedge clk);
            if (rst) return;
            if (!dmem_req_o || dmem_addr_o != a || dmem_be_o != b) stable = 1'b0;
            else cnt++;
        end
        last_req_cnt = cnt;
        check("req_stable", stable, 1'b1);
        if (req_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_request: addr %0h", dmem_addr_o);
        end else begin
            check("dmem_req", {dmem_we_o, dmem_addr_o, dmem_be_o, dmem_we_o ? dmem_wdata_o : 32'h0},
                  req_q.pop_front());
        end
        dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        if (rst) return;
        check("req_drop", dmem_req_o, 1'b0);
        for (int i = 0; i < rv_delay; i++) begin
            @(negedge clk);
            if (rst) return;
        end
        if (dmem_we_o) begin
            for (int j = 0; j < 4; j++)
                if (dmem_be_o[j]) mem_w[dmem_addr_o[9:2]][8*j +: 8] = dmem_wdata_o[8*j +: 8];
            dmem_rdata_i = $urandom;
        end else begin
            dmem_rdata_i = mem_w[dmem_addr_o[9:2]];
        end
        dmem_rvalid_i = 1'b1;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (!rst && dmem_req_o) serve();
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && lsu_done_o) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: rdata %0h", lsu_rdata_o);
            end else begin
                check("commit", {mis_act, lsu_rdata_o}, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat6, wait_cnt;
        rst         = 1'b1;
        lsu_req_i   = 1'b0;
        lsu_we_i    = 1'b0;
        lsu_size_i  = 2'b00;
        lsu_uns_i   = 1'b0;
        lsu_addr_i  = 32'h0;
        lsu_wdata_i = 32'h0;
        for (int w = 0; w < 256; w++) poke(w * 4, $urandom);
        #12;
        check("reset_ctrl", {dmem_req_o, dmem_we_o, dmem_be_o, lsu_stall_o, lsu_done_o, dbg_state, mis_act}, 0);
        check("reset_data", {dmem_addr_o, dmem_wdata_o, lsu_rdata_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // minimum-latency store, byte loads, half store/load
        run_op(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 3, "sw");
        poke(32'h200, 32'h80FF_0000);
        run_op(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 3, "lb");
        run_op(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 3, "lbu");
        run_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_1234, 3, "sh");
        poke(32'h100, 32'hABCD_0000);
        run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 3, "lh");

        // slow grant and slow response
        gnt_delay = 5;
        rv_delay  = 2;
        run_op(1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 10, "lw_slow");
        check("req_hold_cycles", last_req_cnt, 6);
        gnt_delay = 0;

        // reset while waiting for the response
        rv_delay = 30;
        req_q.push_back({1'b0, 32'h110, 4'hf, 32'h0});
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = 2'b10;
        lsu_addr_i = 32'h110;
        wait_cnt   = 0;
        while (dbg_state != WAIT && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("reach_wait", dbg_state, WAIT);
        @(negedge clk);
        #2;
        rst       = 1'b1;
        lsu_req_i = 1'b0;
        #1;
        check("midrst_ctrl", {dmem_req_o, dmem_we_o, dmem_be_o, lsu_stall_o, lsu_done_o, dbg_state, mis_act}, 0);
        check("midrst_data", {dmem_addr_o, dmem_wdata_o, lsu_rdata_o}, 0);
        check("midrst_granted", req_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rv_delay = 0;
        @(negedge clk);
        run_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 3, "lw0");

        // misaligned word
`ifdef LSU_MISALIGN_TRAP_EN
        lat6 = 1;
`else
        lat6 = 3;
`endif
        run_op(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, lat6, "lw_mis");

        // random traffic
        for (int k = 0; k < 60; k++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            int nb;
            sz = 2'($urandom_range(0, 3));
            nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            ad = 32'h100 + $urandom_range(0, 255);
`ifdef LSU_MISALIGN_TRAP_EN
            ad = ad & ~(nb - 1);
`endif
            gnt_delay = $urandom_range(0, 3);
            rv_delay  = $urandom_range(0, 3);
            run_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, 0, "rand");
        end

        repeat (3) @(negedge clk);
        check("leftover", exp_q.size() + req_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
